// File: rtl/regfile_scoreboard_if.sv
// Writeback, decode-read and issue/stall signal bundle between decode/writeback and the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              wb_reg_en;
  logic [5:0]        wb_reg_waddr;
  logic [DATA_W-1:0] wb_reg_wdata;
  logic [5:0]        rs_addr;
  logic [5:0]        rt_addr;
  logic [DATA_W-1:0] rs_rdata;
  logic [DATA_W-1:0] rt_rdata;
  logic              issue_en;
  logic [5:0]        issue_waddr;
  logic              rd_stall;
  logic              pend_ovf;

  modport master (
    output wb_reg_en, wb_reg_waddr, wb_reg_wdata, rs_addr, rt_addr, issue_en, issue_waddr,
    input  rs_rdata, rt_rdata, rd_stall, pend_ovf
  );

  modport slave (
    input  wb_reg_en, wb_reg_waddr, wb_reg_wdata, rs_addr, rt_addr, issue_en, issue_waddr,
    output rs_rdata, rt_rdata, rd_stall, pend_ovf
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// GPR/HI/LO register file with per-register pending-write scoreboard; 1-cycle write, combinational reads.
// Optional macro REGFILE_WB_BYPASS_EN adds same-cycle WB-to-read bypass and retire-aware stall.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  regfile_scoreboard_if.slave  bus
);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [DATA_W-1:0] regs [1:33];
  logic [PEND_W-1:0] pend [1:33];
  logic              ovf_q;
  logic              ret;
  logic              iss;
  logic              same;
  logic              stall;

  function automatic logic mapped(input logic [5:0] a);
    return (a != 6'd0) && (a <= 6'd33);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [5:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (mapped(a)) begin
`ifdef REGFILE_WB_BYPASS_EN
      if (ret && (bus.wb_reg_waddr == a)) d = bus.wb_reg_wdata;
      else d = regs[a];
`else
      d = regs[a];
`endif
    end
    return d;
  endfunction

  // A source is busy while writes are outstanding; with bypass, the retiring write no longer counts.
  function automatic logic busy(input logic [5:0] a);
    logic b;
    b = 1'b0;
    if (mapped(a)) begin
`ifdef REGFILE_WB_BYPASS_EN
      if (ret && (bus.wb_reg_waddr == a)) b = (pend[a] > {{(PEND_W-1){1'b0}}, 1'b1});
      else b = (pend[a] != '0);
`else
      b = (pend[a] != '0);
`endif
    end
    return b;
  endfunction

  always_comb begin
    ret   = bus.wb_reg_en && mapped(bus.wb_reg_waddr);
    stall = busy(bus.rs_addr) || busy(bus.rt_addr);
    iss   = bus.issue_en && !stall && mapped(bus.issue_waddr);
    same  = iss && ret && (bus.issue_waddr == bus.wb_reg_waddr);
  end

  assign bus.rs_rdata = read_port(bus.rs_addr);
  assign bus.rt_rdata = read_port(bus.rt_addr);
  assign bus.rd_stall = stall;
  assign bus.pend_ovf = ovf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= 33; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      if (ret) regs[bus.wb_reg_waddr] <= bus.wb_reg_wdata;
      // Issue and retire to the same register cancel out.
      if (iss && !same) begin
        if (pend[bus.issue_waddr] == PEND_MAX) ovf_q <= 1'b1;
        else pend[bus.issue_waddr] <= pend[bus.issue_waddr] + 1'b1;
      end
      if (ret && !same && (pend[bus.wb_reg_waddr] != '0))
        pend[bus.wb_reg_waddr] <= pend[bus.wb_reg_waddr] - 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard against an array/counter reference model.
module tb_regfile_scoreboard;
  localparam int PEND_MAX = 3;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] m_reg  [0:63];
  int          m_pend [0:63];
  bit          m_ovf;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid(input int a);
    return (a >= 1) && (a <= 33);
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    if (!m_valid(a)) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (bus.wb_reg_en && (int'(bus.wb_reg_waddr) == a)) return bus.wb_reg_wdata;
`endif
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input int a);
    int eff;
    if (!m_valid(a)) return 1'b0;
    eff = m_pend[a];
`ifdef REGFILE_WB_BYPASS_EN
    if (bus.wb_reg_en && (int'(bus.wb_reg_waddr) == a)) eff = eff - 1;
`endif
    return eff > 0;
  endfunction

  function automatic bit exp_stall();
    return exp_busy(int'(bus.rs_addr)) || exp_busy(int'(bus.rt_addr));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 0;
    end
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input bit stall);
    int ia, wa;
    bit iss, ret;
    ia  = int'(bus.issue_waddr);
    wa  = int'(bus.wb_reg_waddr);
    iss = bus.issue_en && !stall && m_valid(ia);
    ret = bus.wb_reg_en && m_valid(wa);
    if (ret) m_reg[wa] = bus.wb_reg_wdata;
    if (iss && ret && ia == wa) return;
    if (iss) begin
      if (m_pend[ia] == PEND_MAX) m_ovf = 1'b1;
      else m_pend[ia] = m_pend[ia] + 1;
    end
    if (ret && m_pend[wa] > 0) m_pend[wa] = m_pend[wa] - 1;
  endtask

  task automatic compare();
    check("rs_rdata", bus.rs_rdata, exp_read(int'(bus.rs_addr)));
    check("rt_rdata", bus.rt_rdata, exp_read(int'(bus.rt_addr)));
    check("rd_stall", {31'h0, bus.rd_stall}, {31'h0, exp_stall()});
    check("pend_ovf", {31'h0, bus.pend_ovf}, {31'h0, m_ovf});
  endtask

  // Compare at the falling edge, then advance the model with the rising edge.
  task automatic cycle();
    bit st;
    @(negedge clk);
    compare();
    st = exp_stall();
    @(posedge clk);
    model_edge(st);
    #1;
  endtask

  task automatic idle();
    bus.wb_reg_en    = 1'b0;
    bus.wb_reg_waddr = 6'd0;
    bus.wb_reg_wdata = 32'h0;
    bus.rs_addr      = 6'd0;
    bus.rt_addr      = 6'd0;
    bus.issue_en     = 1'b0;
    bus.issue_waddr  = 6'd0;
  endtask

  task automatic wb(input logic [5:0] a, input logic [31:0] d);
    bus.wb_reg_en    = 1'b1;
    bus.wb_reg_waddr = a;
    bus.wb_reg_wdata = d;
  endtask

  task automatic issue(input logic [5:0] a);
    bus.issue_en    = 1'b1;
    bus.issue_waddr = a;
  endtask

  function automatic logic [5:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 11));
    case (r)
      0:       return 6'd0;
      7:       return 6'd32;
      8:       return 6'd33;
      9:       return 6'd40;
      10:      return 6'd63;
      11:      return 6'($urandom_range(0, 63));
      default: return 6'(r);
    endcase
  endfunction

  initial begin
    resetn = 1'b1;
    idle();
    model_reset();
    bus.rs_addr = 6'd5;
    bus.rt_addr = 6'd33;
    #1 resetn = 1'b0;
    #1;
    check("rst_rs", bus.rs_rdata, 32'h0);
    check("rst_rt", bus.rt_rdata, 32'h0);
    check("rst_stall", {31'h0, bus.rd_stall}, 32'h0);
    check("rst_ovf", {31'h0, bus.pend_ovf}, 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cycle();

    // Basic write/read, $zero and unmapped writes
    idle(); wb(6'd7, 32'h1234_5678); cycle();
    idle(); bus.rs_addr = 6'd7; #1;
    check("wr_r7", bus.rs_rdata, 32'h1234_5678);
    cycle();
    idle(); wb(6'd0, 32'hFFFF_FFFF); cycle();
    idle(); wb(6'd40, 32'h0000_FFFF); cycle();
    idle(); bus.rs_addr = 6'd0; bus.rt_addr = 6'd40; #1;
    check("rd_r0", bus.rs_rdata, 32'h0);
    check("rd_a40", bus.rt_rdata, 32'h0);
    cycle();

    // Bypass / retire timing on r9
    idle(); issue(6'd9); cycle();
    idle(); bus.rs_addr = 6'd9; #1;
    check("byp_pend", {31'h0, bus.rd_stall}, 32'h1);
    cycle(); cycle();
    idle(); bus.rs_addr = 6'd9; wb(6'd9, 32'hDEAD_BEEF); #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_stall", {31'h0, bus.rd_stall}, 32'h0);
    check("byp_data", bus.rs_rdata, 32'hDEAD_BEEF);
`else
    check("nobyp_stall", {31'h0, bus.rd_stall}, 32'h1);
`endif
    cycle();
    idle(); bus.rs_addr = 6'd9; #1;
    check("after_wb_stall", {31'h0, bus.rd_stall}, 32'h0);
    check("after_wb_data", bus.rs_rdata, 32'hDEAD_BEEF);
    cycle();

    // Multiple pending writes to r3
    idle(); issue(6'd3); cycle(); cycle();
    idle(); wb(6'd3, 32'h1); cycle();
    idle(); bus.rs_addr = 6'd3; #1;
    check("multi_one_left", {31'h0, bus.rd_stall}, 32'h1);
    cycle();
    idle(); issue(6'd3); wb(6'd3, 32'h2); cycle();
    idle(); bus.rs_addr = 6'd3; #1;
    check("multi_same_cyc", {31'h0, bus.rd_stall}, 32'h1);
    cycle();
    idle(); wb(6'd3, 32'h3); cycle();
    idle(); bus.rs_addr = 6'd3; #1;
    check("multi_clear", {31'h0, bus.rd_stall}, 32'h0);
    check("multi_data", bus.rs_rdata, 32'h3);
    cycle();

    // Counter saturation on r4
    idle(); issue(6'd4); repeat (3) cycle();
    idle(); #1;
    check("sat_no_ovf", {31'h0, bus.pend_ovf}, 32'h0);
    issue(6'd4); cycle();
    idle(); #1;
    check("sat_ovf", {31'h0, bus.pend_ovf}, 32'h1);
    wb(6'd4, 32'h44); repeat (3) cycle();
    idle(); bus.rs_addr = 6'd4; #1;
    check("sat_clear", {31'h0, bus.rd_stall}, 32'h0);
    check("sat_ovf_sticky", {31'h0, bus.pend_ovf}, 32'h1);
    cycle();

    // HI / LO
    idle(); wb(6'd32, 32'hAAAA_0000); cycle();
    idle(); wb(6'd33, 32'h0000_5555); cycle();
    idle(); bus.rs_addr = 6'd32; bus.rt_addr = 6'd33; #1;
    check("hi_data", bus.rs_rdata, 32'hAAAA_0000);
    check("lo_data", bus.rt_rdata, 32'h0000_5555);
    cycle();
    idle(); issue(6'd33); cycle();
    idle(); bus.rs_addr = 6'd32; bus.rt_addr = 6'd1; #1;
    check("lo_pend_hi_free", {31'h0, bus.rd_stall}, 32'h0);
    bus.rs_addr = 6'd33; #1;
    check("lo_pend_stall", {31'h0, bus.rd_stall}, 32'h1);
    cycle();
    idle(); wb(6'd33, 32'h0000_5556); cycle();

    // Mid-run asynchronous reset
    idle(); bus.rs_addr = 6'd7; bus.rt_addr = 6'd32;
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_rs", bus.rs_rdata, 32'h0);
    check("mid_rst_rt", bus.rt_rdata, 32'h0);
    check("mid_rst_ovf", {31'h0, bus.pend_ovf}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    cycle();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bus.wb_reg_en    = ($urandom_range(0, 1) == 1);
      bus.wb_reg_waddr = rand_addr();
      bus.wb_reg_wdata = $urandom;
      bus.rs_addr      = rand_addr();
      bus.rt_addr      = rand_addr();
      bus.issue_en     = ($urandom_range(0, 2) != 0);
      bus.issue_waddr  = rand_addr();
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        #1;
        model_reset();
        compare();
        resetn = 1'b1;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural register file at the receiving end of the writeback write interface (wb_reg_en / wb_reg_waddr / wb_reg_wdata).
- Holds GPRs 1–31 plus HI (32) and LO (33), with two combinational read ports for decode.
- A per-register pending-write scoreboard produces the decode stall and applies the WB-to-decode bypass.

Parameters:
- DATA_W, 32, width of every register and data port.
- PEND_W, 2, width of each per-register pending-write counter; max count is 2^PEND_W-1.

Ports:
- clk  in  1  core clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- wb_reg_en  in  1  write strobe from writeback.
- wb_reg_waddr  in  6  write address from writeback.
- wb_reg_wdata  in  DATA_W  write data from writeback.
- rs_addr  in  6  read port A address.
- rt_addr  in  6  read port B address.
- rs_rdata  out  DATA_W  read port A data, combinational.
- rt_rdata  out  DATA_W  read port B data, combinational.
- issue_en  in  1  decode issues an instruction that will write issue_waddr.
- issue_waddr  in  6  destination of the issuing instruction.
- rd_stall  out  1  a source is pending and decode must hold.
- pend_ovf  out  1  sticky flag: an issue was dropped because its counter was saturated.

Behaviour:
- Interface (already decided): one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values:
  - All registers = 0, all pending counters = 0, pend_ovf = 0.
  - Read outputs then reflect the zeroed array (0), and rd_stall = 0.
  - Reset asserted mid-operation clears everything immediately; in-flight writes are lost.
- Address map:
  - 0 = $zero: writes ignored, reads 0, never pending.
  - 1–31 = GPR; 32 = HI; 33 = LO.
  - 34–63 unmapped: writes ignored, reads 0, never pending, issue to them ignored.
  - "valid(a)" means 1 ≤ a ≤ 33.
- Write:
  - On the rising clk edge with wb_reg_en=1 and valid(wb_reg_waddr), reg[waddr] takes wb_reg_wdata.
  - Write latency is 1 cycle; the value is visible in the array from the next cycle.
- Read:
  - rs_rdata/rt_rdata are combinational.
  - Bypass: if wb_reg_en and waddr == addr and valid(addr), the port returns wb_reg_wdata. Otherwise it returns reg[addr], or 0 for unmapped/zero addresses.
  - Both ports may read the same address.
- Scoreboard: pend[a] is PEND_W bits for each valid a.
  - Effective issue: iss = issue_en & ~rd_stall & valid(issue_waddr).
  - Effective retire: ret = wb_reg_en & valid(wb_reg_waddr).
  - Same address, iss and ret in one cycle: counter unchanged.
  - iss only: +1. If the counter is already at max, it stays at max, the issue is dropped and pend_ovf is set. pend_ovf is sticky until reset.
  - ret only: -1. A retire with the counter at 0 leaves it at 0 (no underflow) and still writes the data.
  - iss and ret to different addresses update both counters.
- Stall:
  - eff_pend(a) = pend[a] - (ret & waddr==a ? 1 : 0).
  - rd_stall = (eff_pend(rs_addr) > 0) | (eff_pend(rt_addr) > 0). Only valid addresses contribute.
  - Stall uses the current counters only. An instruction reading its own destination does not stall on its own issue.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: same-cycle WB-to-read bypass as above. A retiring write also discounts the pending count (eff_pend).
- Undefined:
  - Reads always return the array, with no bypass path.
  - The stall term uses pend[a] > 0 directly.
  - A consumer therefore waits one extra cycle after the final writeback.

Test Plan:
- Reset: deassert resetn, read rs=5 and rt=33 → both 0, rd_stall=0, pend_ovf=0. Assert resetn mid-run after writes → all reads return 0 immediately.
- Basic write/read: WB writes 0x1234_5678 to r7, then next cycle rs_addr=7 → 0x12345678. Writes to r0 and addr 40 → reads of 0 and 40 return 0.
- Bypass (macro on): issue r9, then hold rs_addr=9. rd_stall=1 until the cycle WB writes 0xDEADBEEF to r9; that cycle rd_stall=0 and rs_rdata=0xDEADBEEF. With the macro off, rd_stall=1 that cycle and clears the next, data from the array.
- Multi-pending: issue r3 twice, then one WB write to r3 → still stalled on r3. The second write → stall clears. Simultaneous issue+WB to r3 keeps the count unchanged.
- Saturation: 3 issues to r4 with PEND_W=2 → count 3. A 4th issue → dropped and pend_ovf=1. 3 WB writes → stall clears; pend_ovf stays 1.
- HI/LO: WB writes 0xAAAA_0000 to addr 32 and 0x0000_5555 to addr 33 → rs=32 and rt=33 return those values; issue to 33 stalls only reads of 33.
